cpu_run_monitor: RTL and testbench
==================================

// Module: cpu_run_monitor
// PURPOSE
//  Synthesizable run controller and write-back tracer for the MIPS cores (single-cycle and pipelined).
//  - Holds the core in reset for a programmable number of cycles.
//  - Runs the core until a stop condition is met.
//  - Captures register-file writes into a trace FIFO, read out through a valid/ready port.
//  - Replaces fixed-length bench loops with a parametrised, halt-aware run, usable on FPGA and in simulation.
// PARAMETERS
//  DW          32      data width of wb_data / trace_data
//  AW          32      PC width
//  DEPTH       16      trace FIFO entries; power of 2, >=2
//  RST_CYCLES  1       cycles core_reset is held after start
//  MAX_CYCLES  1024    run cycle limit (timeout)
//  HALT_PC     32'hFFFF_FFFC  PC value that ends the run
//  LOOP_LIMIT  4       consecutive identical-PC cycles that count as a stuck loop
// PORTS
//  clk         in   1      core clock
//  reset       in   1      synchronous, active-low block reset
//  start       in   1      pulse; begins a run when in IDLE or DONE
//  core_reset  out  1      active-high reset to the CPU core
//  pc_in       in   AW     core PC
//  wb_en       in   1      register-file write strobe
//  wb_addr     in   5      write destination (Rd or Rt)
//  wb_data     in   DW     write-back data
//  trace_valid out  1      FIFO head entry available
//  trace_ready in   1      consumer accepts head entry
//  trace_addr  out  5      head entry destination
//  trace_data  out  DW     head entry data
//  done        out  1      run finished and FIFO drained
//  halt_cause  out  2      0 none, 1 HALT_PC, 2 timeout, 3 stuck loop
//  cycle_count out  32     RUN cycles elapsed
//  overflow    out  1      sticky; a write was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//  - State goes to IDLE.
//  - Outputs: core_reset=1, trace_valid=0, done=0, halt_cause=0, cycle_count=0, overflow=0.
//  - FIFO is emptied.
//  - A mid-run reset aborts the run immediately; the core stays held in reset.
//  FSM states:
//  - IDLE: core_reset=1. On start: clear counters, FIFO, overflow and halt_cause, then go to HOLD.
//  - HOLD: core_reset=1 for exactly RST_CYCLES cycles, then go to RUN.
//  - RUN: core_reset=0; cycle_count increments every cycle. Stop priority is HALT_PC > timeout > loop.
//    - pc_in==HALT_PC: cause 1.
//    - cycle_count==MAX_CYCLES-1: cause 2.
//    - pc_in equal to the previous cycle's PC for LOOP_LIMIT cycles: cause 3.
//    - When a stop condition is met: latch halt_cause, set core_reset=1, go to DRAIN.
//  - DRAIN: wait until the FIFO is empty, then go to DONE.
//  - DONE: done=1 and cycle_count is frozen. start re-enters HOLD and clears the run state (as from IDLE).
//  FIFO capture:
//  - Active in RUN only, including the stop cycle.
//  - Writes with wb_en=1 and wb_addr==0 are not captured ($zero).
//  - Push is registered: an entry written at edge N is visible with trace_valid=1 after edge N.
//  - Pop happens at an edge where trace_valid && trace_ready.
//  - Push and pop in the same cycle while full are both accepted; no drop.
//  - Push while full with no pop: the entry is dropped and overflow is set (sticky).
//  - Pointers are log2(DEPTH)+1 bits and wrap naturally; full when MSBs differ and the rest are equal.
//  - trace outputs are held stable while trace_valid && !trace_ready.
//  Other rules:
//  - start outside IDLE or DONE is ignored.
//  - The loop counter resets whenever the PC changes; the first RUN cycle compares against HOLD's sampled PC.
// CONFIGURATION
//  RUN_MON_PC_TRACE_EN
//  - Defined: each FIFO entry also stores pc_in, exposed on an extra output port trace_pc [AW-1:0].
//  - Undefined: no trace_pc port and no PC storage in the FIFO.
// STRUCTURE
//  Package cpu_run_pkg:
//  - run_state_t (IDLE, HOLD, RUN, DRAIN, DONE)
//  - halt_cause_t constants (HC_NONE, HC_HALTPC, HC_TIMEOUT, HC_LOOP)
//  - trace entry struct
//  Sub-module trace_fifo:
//  - Generic synchronous FIFO parametrised by width and DEPTH.
//  - Provides full, empty and a drop flag.
// TESTING
//  1 RST_CYCLES=3, start at cycle 2 -> core_reset high in cycles 2-4 (HOLD), low from cycle 5.
//  2 PC goes 0,4,8 then HALT_PC; wb at addr 8 data 5 and addr 0 data 7
//    -> halt_cause=1, FIFO holds only {8,5}, done after the pop.
//  3 MAX_CYCLES=10, PC increments forever -> halt_cause=2, cycle_count=10.
//  4 PC sticks at 0x20, LOOP_LIMIT=4 -> halt_cause=3 on the 4th equal cycle.
//  5 DEPTH=4, 6 writes with trace_ready=0 -> 4 entries kept in order, overflow=1.
//    Then a full push+pop in the same cycle -> no drop.
//  6 reset low mid-RUN with 2 entries queued -> IDLE, core_reset=1, trace_valid=0, cycle_count=0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared types for the CPU run monitor
//
// Purpose: run-controller state encoding and halt-cause codes used by
// cpu_run_monitor and its testbench.
// Ports: none (package).

package cpu_run_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HOLD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    typedef enum logic [1:0] {
        HC_NONE    = 2'd0,
        HC_HALTPC  = 2'd1,
        HC_TIMEOUT = 2'd2,
        HC_LOOP    = 2'd3
    } halt_cause_t;

    // Register-file destination width (MIPS has 32 registers).
    localparam int WB_AW = 5;

endpackage

// File: rtl/cpu_run_monitor_if.sv
// rtl/cpu_run_monitor_if.sv - trace read-out port of the CPU run monitor
//
// Purpose: groups the trace valid/ready stream. master = monitor side
// (drives valid/addr/data), slave = consumer side (drives ready).
// Signals: trace_valid, trace_ready, trace_addr[4:0], trace_data[DW-1:0],
//          trace_pc[AW-1:0] only when RUN_MON_PC_TRACE_EN is defined.

`ifdef RUN_MON_PC_TRACE_EN
interface cpu_run_monitor_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic                             trace_valid;
    logic                             trace_ready;
    logic [cpu_run_pkg::WB_AW-1:0]    trace_addr;
    logic [DW-1:0]                    trace_data;
    logic [AW-1:0]                    trace_pc;

    modport master (output trace_valid, trace_addr, trace_data, trace_pc, input trace_ready);
    modport slave  (input trace_valid, trace_addr, trace_data, trace_pc, output trace_ready);
endinterface
`else
interface cpu_run_monitor_if #(
    parameter int DW = 32
);
    logic                             trace_valid;
    logic                             trace_ready;
    logic [cpu_run_pkg::WB_AW-1:0]    trace_addr;
    logic [DW-1:0]                    trace_data;

    modport master (output trace_valid, trace_addr, trace_data, input trace_ready);
    modport slave  (input trace_valid, trace_addr, trace_data, output trace_ready);
endinterface
`endif

// File: rtl/cpu_run_monitor_trace_fifo.sv
// rtl/cpu_run_monitor_trace_fifo.sv - generic synchronous FIFO for trace entries
//
// Purpose: DEPTH-entry FIFO with registered push, first-word-fall-through head.
// Ports: clk, reset (sync, active-low), clear (sync flush), push/push_data,
//        pop/pop_data, full, empty, drop (push refused because full, no pop).

module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty,
    output logic         drop
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_pop;
    logic         do_push;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

    // A pop in the same cycle frees the slot the push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/cpu_run_monitor.sv
// rtl/cpu_run_monitor.sv - run controller and write-back tracer for MIPS cores
//
// Purpose: holds the core in reset, runs it until HALT_PC / timeout / stuck
// loop, captures non-$zero register writes into a trace FIFO and reports done
// once the FIFO has drained.
// Ports: clk, reset (sync, active-low), start, core_reset, pc_in, wb_en,
//        wb_addr, wb_data, trace (cpu_run_monitor_if.master), done,
//        halt_cause, cycle_count, overflow.
// Macro: RUN_MON_PC_TRACE_EN - store pc_in with each entry, exposed as trace_pc.

module cpu_run_monitor
    import cpu_run_pkg::*;
#(
    parameter int            DW         = 32,
    parameter int            AW         = 32,
    parameter int            DEPTH      = 16,
    parameter int            RST_CYCLES = 1,
    parameter int            MAX_CYCLES = 1024,
    parameter logic [AW-1:0] HALT_PC    = AW'(32'hFFFF_FFFC),
    parameter int            LOOP_LIMIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             core_reset,
    input  logic [AW-1:0]    pc_in,
    input  logic             wb_en,
    input  logic [WB_AW-1:0] wb_addr,
    input  logic [DW-1:0]    wb_data,
    cpu_run_monitor_if.master trace,
    output logic             done,
    output logic [1:0]       halt_cause,
    output logic [31:0]      cycle_count,
    output logic             overflow
);
`ifdef RUN_MON_PC_TRACE_EN
    typedef struct packed {
        logic [AW-1:0]    pc;
        logic [WB_AW-1:0] addr;
        logic [DW-1:0]    data;
    } trace_entry_t;
`else
    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [DW-1:0]    data;
    } trace_entry_t;
`endif

    run_state_t   state, state_next;
    halt_cause_t  cause_q, cause_next;
    logic [31:0]  hold_cnt;
    logic [31:0]  loop_cnt;
    logic [AW-1:0] prev_pc;
    logic         start_ok, pc_same, hit_halt, hit_timeout, hit_loop, stop;
    logic         push, pop, fifo_empty, fifo_drop, unused_fifo_full;
    trace_entry_t push_entry, head;

    assign start_ok    = start && (state == IDLE || state == DONE);
    assign pc_same     = (pc_in == prev_pc);
    assign hit_halt    = (pc_in == HALT_PC);
    assign hit_timeout = (cycle_count == 32'(MAX_CYCLES - 1));
    // loop_cnt holds the equal-PC cycles seen so far; this cycle is one more.
    assign hit_loop    = pc_same && (loop_cnt == 32'(LOOP_LIMIT - 1));

    always_comb begin
        cause_next = HC_NONE;
        if (hit_halt)         cause_next = HC_HALTPC;
        else if (hit_timeout) cause_next = HC_TIMEOUT;
        else if (hit_loop)    cause_next = HC_LOOP;
    end

    assign stop = (state == RUN) && (cause_next != HC_NONE);

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next state and state-decoded outputs
    always_comb begin
        state_next = state;
        core_reset = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = HOLD;
            HOLD:  if (hold_cnt == 32'(RST_CYCLES - 1)) state_next = RUN;
            RUN: begin
                core_reset = 1'b0;
                if (stop) state_next = DRAIN;
            end
            DRAIN: if (fifo_empty) state_next = DONE;
            DONE: begin
                done = 1'b1;
                if (start) state_next = HOLD;
            end
            default: state_next = IDLE;
        endcase
    end

    // Run counters and status
    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_cnt    <= '0;
            loop_cnt    <= '0;
            prev_pc     <= '0;
            cycle_count <= '0;
            cause_q     <= HC_NONE;
            overflow    <= 1'b0;
        end else begin
            // Sampled in every state so the first RUN cycle compares to HOLD's PC.
            prev_pc <= pc_in;
            if (start_ok) begin
                hold_cnt    <= '0;
                loop_cnt    <= '0;
                cycle_count <= '0;
                cause_q     <= HC_NONE;
                overflow    <= 1'b0;
            end else begin
                if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
                if (state == RUN) begin
                    cycle_count <= cycle_count + 1'b1;
                    loop_cnt    <= pc_same ? loop_cnt + 1'b1 : '0;
                    if (stop) cause_q <= cause_next;
                end
                if (fifo_drop) overflow <= 1'b1;
            end
        end
    end

    assign halt_cause = cause_q;

    // Capture runs through the stop cycle; writes to $zero are not traced.
    assign push            = (state == RUN) && wb_en && (wb_addr != '0);
    assign pop             = trace.trace_valid && trace.trace_ready;
    assign push_entry.addr = wb_addr;
    assign push_entry.data = wb_data;
`ifdef RUN_MON_PC_TRACE_EN
    assign push_entry.pc   = pc_in;
`endif

    trace_fifo #(
        .W     ($bits(trace_entry_t)),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign trace.trace_valid = !fifo_empty;
    assign trace.trace_addr  = head.addr;
    assign trace.trace_data  = head.data;
`ifdef RUN_MON_PC_TRACE_EN
    assign trace.trace_pc    = head.pc;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// tb/tb_cpu_run_monitor.sv - self-checking bench for cpu_run_monitor

module tb_cpu_run_monitor;
    import cpu_run_pkg::*;

    localparam int            DW         = 32;
    localparam int            AW         = 32;
    localparam int            DEPTH      = 4;
    localparam int            RST_CYCLES = 3;
    localparam int            MAX_CYCLES = 10;
    localparam int            LOOP_LIMIT = 4;
    localparam logic [AW-1:0] HALT_PC    = 32'hFFFF_FFFC;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          core_reset;
    logic [AW-1:0] pc_in;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [DW-1:0] wb_data;
    logic          done;
    logic [1:0]    halt_cause;
    logic [31:0]   cycle_count;
    logic          overflow;

`ifdef RUN_MON_PC_TRACE_EN
    cpu_run_monitor_if #(.DW(DW), .AW(AW)) trace ();
`else
    cpu_run_monitor_if #(.DW(DW)) trace ();
`endif

    cpu_run_monitor #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES),
        .MAX_CYCLES(MAX_CYCLES), .HALT_PC(HALT_PC), .LOOP_LIMIT(LOOP_LIMIT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .core_reset  (core_reset),
        .pc_in       (pc_in),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .trace       (trace),
        .done        (done),
        .halt_cause  (halt_cause),
        .cycle_count (cycle_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per-run stimulus, indexed by RUN cycle
    logic [AW-1:0] pcs [MAX_CYCLES];
    logic          wbe [MAX_CYCLES];
    logic [4:0]    wba [MAX_CYCLES];
    logic [DW-1:0] wbd [MAX_CYCLES];
    logic          rdy [MAX_CYCLES];
    logic [AW-1:0] hold_pc;

    typedef struct {
        logic [4:0]    addr;
        logic [DW-1:0] data;
        logic [AW-1:0] pc;
    } ent_t;
    ent_t q[$];
    bit   m_ovf;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Stop point from the rules: HALT_PC first, then timeout, then LOOP_LIMIT equal PCs.
    function automatic void expect_stop(output int stop, output int cause);
        int same_run = 0;
        logic [AW-1:0] prev = hold_pc;
        stop  = MAX_CYCLES - 1;
        cause = 2;
        for (int k = 0; k < MAX_CYCLES; k++) begin
            same_run = (pcs[k] == prev) ? same_run + 1 : 0;
            prev = pcs[k];
            if (pcs[k] == HALT_PC)        begin stop = k; cause = 1; return; end
            if (k == MAX_CYCLES - 1)      begin stop = k; cause = 2; return; end
            if (same_run >= LOOP_LIMIT)   begin stop = k; cause = 3; return; end
        end
    endfunction

    // One clock of the queue model, evaluated on the inputs of the current cycle.
    task automatic model_cycle(input bit capture);
        bit popped = 0;
        int sz = q.size();
        if (sz > 0) begin
            check_eq("trace_valid", trace.trace_valid, 1);
            if (trace.trace_ready) begin
                check_eq("trace_addr", trace.trace_addr, q[0].addr);
                check_eq("trace_data", trace.trace_data, q[0].data);
`ifdef RUN_MON_PC_TRACE_EN
                check_eq("trace_pc", trace.trace_pc, q[0].pc);
`endif
                void'(q.pop_front());
                popped = 1;
            end
        end else begin
            check_eq("trace_idle", trace.trace_valid, 0);
        end
        if (capture && wb_en && wb_addr != 0) begin
            if (sz < DEPTH || popped) q.push_back('{wb_addr, wb_data, pc_in});
            else m_ovf = 1;
        end
    endtask

    task automatic start_and_hold(input string name);
        int hc = 0;
        start = 1; pc_in = hold_pc; wb_en = 0; trace.trace_ready = 0;
        step();
        start = 0;
        while (core_reset === 1'b1 && hc < 20) begin
            start = (hc == 0);   // start during HOLD must be ignored
            step();
            hc++;
        end
        start = 0;
        check_eq({name, "_hold_len"}, hc, RST_CYCLES);
    endtask

    task automatic run_and_check(input string name);
        int exp_stop, exp_cause, n;
        logic [31:0] frozen;
        q.delete();
        m_ovf = 0;
        expect_stop(exp_stop, exp_cause);
        start_and_hold(name);
        for (int k = 0; k <= exp_stop; k++) begin
            pc_in = pcs[k]; wb_en = wbe[k]; wb_addr = wba[k]; wb_data = wbd[k];
            trace.trace_ready = rdy[k];
            start = (k == 1);
            check_eq({name, "_run_core_reset"}, core_reset, 0);
            model_cycle(1);
            step();
        end
        start = 0; wb_en = 0;
        check_eq({name, "_stop_core_reset"}, core_reset, 1);
        n = 0;
        while (q.size() > 0 && n < 60) begin
            trace.trace_ready = 1'($urandom_range(0, 1));
            check_eq({name, "_done_early"}, done, 0);
            model_cycle(0);
            step();
            n++;
        end
        trace.trace_ready = 0;
        n = 0;
        while (done !== 1'b1 && n < 3) begin step(); n++; end
        check_eq({name, "_done"}, done, 1);
        check_eq({name, "_drained"}, trace.trace_valid, 0);
        check_eq({name, "_cause"}, halt_cause, exp_cause);
        check_eq({name, "_cycles"}, cycle_count, exp_stop + 1);
        check_eq({name, "_overflow"}, overflow, m_ovf);
        frozen = cycle_count;
        pc_in = $urandom; step(); step();
        check_eq({name, "_frozen"}, cycle_count, 32'(exp_stop + 1));
        check_eq({name, "_done_hold"}, done, 1);
    endtask

    task automatic clear_stim();
        for (int k = 0; k < MAX_CYCLES; k++) begin
            pcs[k] = 32'h100 + 32'(4 * k); wbe[k] = 0; wba[k] = 0; wbd[k] = 0; rdy[k] = 0;
        end
        hold_pc = 32'hFC;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; start = 0; pc_in = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
        trace.trace_ready = 0;
        repeat (3) step();
        check_eq("rst_core_reset", core_reset, 1);
        check_eq("rst_valid", trace.trace_valid, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cause", halt_cause, 0);
        check_eq("rst_cycles", cycle_count, 0);
        check_eq("rst_overflow", overflow, 0);
        reset = 1;
        step();
        check_eq("idle_core_reset", core_reset, 1);

        // HALT_PC run: only the non-$zero write is traced
        clear_stim();
        hold_pc = 0;
        pcs[0] = 0; pcs[1] = 4; pcs[2] = 8; pcs[3] = HALT_PC;
        wbe[1] = 1; wba[1] = 8; wbd[1] = 5;
        wbe[2] = 1; wba[2] = 0; wbd[2] = 7;
        run_and_check("halt");

        // Timeout with an ever-increasing PC
        clear_stim();
        run_and_check("timeout");

        // Stuck loop at 0x20
        clear_stim();
        for (int k = 0; k < MAX_CYCLES; k++) pcs[k] = 32'h20;
        run_and_check("loop");

        // Six writes into a 4-deep FIFO with no consumer
        clear_stim();
        for (int k = 0; k < 6; k++) begin wbe[k] = 1; wba[k] = 5'(k + 1); wbd[k] = $urandom; end
        run_and_check("ovf");

        // Full FIFO with simultaneous push and pop
        clear_stim();
        for (int k = 0; k < 5; k++) begin wbe[k] = 1; wba[k] = 5'(k + 10); wbd[k] = $urandom; end
        rdy[4] = 1;
        run_and_check("fullpp");

        // Randomised runs
        for (int r = 0; r < 25; r++) begin
            hold_pc = 32'($urandom_range(0, 3) * 4);
            for (int k = 0; k < MAX_CYCLES; k++) begin
                pcs[k] = ($urandom_range(0, 11) == 0) ? HALT_PC : 32'($urandom_range(0, 2) * 4);
                wbe[k] = 1'($urandom_range(0, 1));
                wba[k] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                wbd[k] = $urandom;
                rdy[k] = 1'($urandom_range(0, 1));
            end
            run_and_check("rand");
        end

        // Reset in the middle of a run with two entries queued
        clear_stim();
        start_and_hold("midrst");
        for (int k = 0; k < 2; k++) begin
            pc_in = pcs[k]; wb_en = 1; wb_addr = 5'(k + 3); wb_data = $urandom;
            step();
        end
        wb_en = 0;
        check_eq("midrst_queued", trace.trace_valid, 1);
        reset = 0;
        step();
        reset = 1;
        check_eq("midrst_core_reset", core_reset, 1);
        check_eq("midrst_valid", trace.trace_valid, 0);
        check_eq("midrst_cycles", cycle_count, 0);
        check_eq("midrst_done", done, 0);
        step();
        check_eq("midrst_idle", core_reset, 1);

        // A normal run from IDLE after the abort
        clear_stim();
        pcs[2] = HALT_PC; wbe[0] = 1; wba[0] = 31; wbd[0] = 32'hDEAD_BEEF; rdy[1] = 1;
        run_and_check("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
